// File: rtl/full_subtractor.sv
// full_subtractor -- single-bit registered full subtractor (a - b - bin).
//
// Parallel mode (serial=0): every valid cycle is an independent 1-bit op
// using c as borrow-in. Serial mode (serial=1): words are fed LSB-first,
// c is the initial borrow on the start-of-word cycle (sow=1), and later
// bits chain from the registered borrow. Outputs are purely registered.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   in_valid  in   operands valid; result captured when high
//   a, b      in   minuend / subtrahend bit
//   c         in   borrow-in (parallel mode, or serial start-of-word)
//   serial    in   1 = bit-serial chaining mode
//   sow       in   start of word in serial mode, qualified by in_valid
//   diff      out  registered difference bit
//   borrow    out  registered borrow-out (also the serial chain state)
//   out_valid out  one-cycle pulse per accepted in_valid
module full_subtractor (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic serial,
  input  logic sow,
  output logic diff,
  output logic borrow,
  output logic out_valid
);

  logic diff_q, diff_d;
  logic borrow_q, borrow_d;
  logic vld_q, vld_d;
  logic bin;
  logic diff_n, borrow_n;

  // Chain from the registered borrow only for non-first bits of a serial
  // word; the rule is re-evaluated each cycle, so toggling serial mid-word
  // needs no extra state.
  assign bin      = (serial && !sow) ? borrow_q : c;
  assign diff_n   = a ^ b ^ bin;
  assign borrow_n = (~a & b) | (~(a ^ b) & bin);

  // in_valid gates the whole update, so unknown operands during bubbles
  // never reach the registers and the chain state survives the bubble.
  always_comb begin
    diff_d   = diff_q;
    borrow_d = borrow_q;
    vld_d    = 1'b0;
    if (in_valid) begin
      diff_d   = diff_n;
      borrow_d = borrow_n;
      vld_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q   <= 1'b0;
      borrow_q <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      vld_q    <= vld_d;
    end
  end

  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_subtractor.sv
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst, in_valid, a, b, c, serial, sow;
  logic diff, borrow, out_valid;

  int checks = 0;
  int errors = 0;

  // scoreboard: {diff, borrow} pushed at drive time, popped at output time
  logic [1:0] sb_q[$];
  // bench model of the held outputs / chain borrow
  logic md = 1'b0, mb = 1'b0;
  logic [3:0] word;

  full_subtractor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .serial(serial), .sow(sow), .diff(diff), .borrow(borrow),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1 time unit after the posedge.
  task automatic step(input string tag, input logic v, input logic ia, input logic ib,
                      input logic ic, input logic iser, input logic isow);
    logic bin;
    int r;
    logic [1:0] e;
    @(negedge clk);
    in_valid = v; a = ia; b = ib; c = ic; serial = iser; sow = isow;
    if (v) begin
      bin = (iser && !isow) ? mb : ic;
      r   = int'(ia) - int'(ib) - int'(bin);
      md  = r[0];
      mb  = (r < 0);
      sb_q.push_back({md, mb});
    end
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 8'(out_valid), 8'(v));
    if (v) begin
      e = sb_q.pop_front();
      chk({tag, ".diff"},   8'(diff),   8'(e[1]));
      chk({tag, ".borrow"}, 8'(borrow), 8'(e[0]));
    end else begin
      chk({tag, ".hold_diff"},   8'(diff),   8'(md));
      chk({tag, ".hold_borrow"}, 8'(borrow), 8'(mb));
    end
  endtask

  task automatic sword(input string tag, input logic [3:0] av, input logic [3:0] bv,
                       input int bubble_after, input logic [3:0] exp_w, input logic exp_b);
    word = '0;
    for (int i = 0; i < 4; i++) begin
      step(tag, 1'b1, av[i], bv[i], 1'b0, 1'b1, (i == 0));
      word[i] = diff;
      if (i == bubble_after) step({tag, ".bub"}, 1'b0, ~av[i], bv[i], 1'b1, 1'b0, 1'b1);
    end
    chk({tag, ".word"},   8'(word),   8'(exp_w));
    chk({tag, ".wborrow"}, 8'(borrow), 8'(exp_b));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 0; b = 0; c = 0; serial = 0; sow = 0;
    #1;
    chk("rst.diff", 8'(diff), 8'd0);
    chk("rst.borrow", 8'(borrow), 8'd0);
    chk("rst.out_valid", 8'(out_valid), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // exhaustive parallel, plus literal truth-table spot checks
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      step("par", 1'b1, abc[2], abc[1], abc[0], 1'b0, 1'b0);
      if (i == 1) chk("tt001", {6'd0, diff, borrow}, 8'b11);
      if (i == 7) chk("tt111", {6'd0, diff, borrow}, 8'b11);
    end

    // hold on bubble with toggling operands
    step("cap011", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("cap011.lit", {6'd0, diff, borrow}, 8'b01);
    for (int i = 0; i < 3; i++)
      step("bubble", 1'b0, i[0], ~i[0], i[1], i[0], 1'b1);

    // serial 5 - 3 = 2, 3 - 5 = 14 borrow, and 3 - 5 with a bubble
    sword("s5m3", 4'd5, 4'd3, -1, 4'd2, 1'b0);
    sword("s3m5", 4'd3, 4'd5, -1, 4'd14, 1'b1);
    sword("s3m5b", 4'd3, 4'd5, 1, 4'd14, 1'b1);

    // async reset between edges while borrow = 1 and out_valid = 1
    chk("pre_rst", {6'd0, borrow, out_valid}, 8'b11);
    #3;
    rst = 1'b1;
    #1;
    chk("arst.diff", 8'(diff), 8'd0);
    chk("arst.borrow", 8'(borrow), 8'd0);
    chk("arst.out_valid", 8'(out_valid), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    md = 1'b0; mb = 1'b0;
    // no sow: chains from 0 -> 1-0-0 = diff 1, borrow 0
    step("post_rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("post_rst.lit", {6'd0, diff, borrow}, 8'b10);

    // sow with c = 1, then chained bit
    step("sowc1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("sowc1.lit", {6'd0, diff, borrow}, 8'b11);
    step("chain", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("chain.lit", {6'd0, diff, borrow}, 8'b11);

    // mid-word switch to parallel uses c, not the chain
    step("switch", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("switch.lit", {6'd0, diff, borrow}, 8'b10);
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
# full_subtractor

Single-bit registered full subtractor computing a − b − c with difference and borrow outputs. An optional bit-serial mode feeds the registered borrow back as the next borrow-in, so multi-bit words can be subtracted LSB-first over successive valid cycles. It is a leaf arithmetic cell, used standalone or as the core of serial subtract datapaths.

## Interface

One clock; reset is asynchronous and active-high.

No parameters.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands valid this cycle; result captured when high
- a  input  1  minuend bit
- b  input  1  subtrahend bit
- c  input  1  borrow-in. Used every valid cycle in parallel mode; used only on start-of-word in serial mode.
- serial  input  1  1 = bit-serial chaining mode, 0 = independent single-bit operations
- sow  input  1  start of word (serial mode only); qualified by in_valid
- diff  output  1  registered difference bit
- borrow  output  1  registered borrow-out
- out_valid  output  1  high for exactly one cycle per accepted in_valid

## Operation

- Effective borrow-in is selected as follows:
  - bin = c when serial = 0.
  - bin = c when serial = 1 and sow = 1.
  - bin = borrow register (current `borrow` output) when serial = 1 and sow = 0.
- Arithmetic (1-bit, no overflow beyond borrow):
  - diff_n = a ^ b ^ bin
  - borrow_n = (~a & b) | (~(a ^ b) & bin)
- Reference truth table, a b c → diff borrow:
  - 000→00, 001→11, 010→11, 011→01
  - 100→10, 101→00, 110→00, 111→11
- On a clock edge with in_valid = 1: diff ← diff_n, borrow ← borrow_n, out_valid ← 1.
- On a clock edge with in_valid = 0: diff and borrow hold, out_valid ← 0. Serial chain state is preserved across bubbles.
- In serial mode, words are presented LSB-first. The borrow after the MSB cycle is the word borrow (1 means a < b + initial c, unsigned).
- sow and serial are ignored when in_valid = 0.
- Switching serial mid-word is legal. The selection rule above is applied per cycle with no extra state.
- No X propagation from a/b/c/sow/serial when in_valid = 0.

## Timing

- Latency 1 cycle: inputs sampled at edge N; diff, borrow and out_valid are visible after edge N.
- Throughput: one bit per cycle; back-to-back in_valid fully supported.
- Reset (asynchronous assert, takes effect immediately regardless of clk): diff = 0, borrow = 0, out_valid = 0.
- Reset deassertion is synchronous to clk by the surrounding system. The first valid capture occurs on the first rising edge with rst = 0 and in_valid = 1.
- Reset mid-word in serial mode clears the chained borrow to 0. The next word must start with sow = 1; if it starts with sow = 0, it chains from borrow = 0.
- Outputs are purely registered; no combinational path from inputs to outputs.

## Test plan

- **Exhaustive parallel:** serial = 0, in_valid = 1, apply abc = 000…111 in order, one per cycle. One cycle later each result matches the truth table (e.g. 001 → diff 1, borrow 1; 111 → diff 1, borrow 1). out_valid is high for 8 cycles.
- **Hold on bubble:** capture 011 (→ 0,1), then drop in_valid for 3 cycles with a/b/c toggling. diff = 0 and borrow = 1 hold; out_valid = 0.
- **Serial 5 − 3:** serial = 1, a bits 1,0,1,0 and b bits 1,1,0,0 (LSB-first), c = 0, sow on first bit. diff sequence 0,1,0,0 (= 2), final borrow 0.
- **Serial 3 − 5:** a bits 1,1,0,0 and b bits 1,0,1,0, c = 0, sow first. diff sequence 0,1,1,1 (= 14 = −2 mod 16), final borrow 1. Repeat with one in_valid bubble between bits 1 and 2; results are identical.
- **Async reset:** assert rst between clock edges while borrow = 1 and out_valid = 1. All outputs read 0 immediately, before the next edge. After release, a serial word without sow chains from borrow = 0.
- **sow with c = 1 in serial mode:** a = 0, b = 0, c = 1, sow = 1 → diff 1, borrow 1. Next bit a = 0, b = 0, sow = 0 → diff 1, borrow 1 (chained).
